// File: rtl/pio_gpio_ctrl.sv
// Avalon-MM GPIO block: blinkable outputs, synchronised and debounced inputs,
// per-bit edge capture with W1C clear and a maskable level interrupt.
module pio_gpio_ctrl #(
    parameter int unsigned N_OUT   = 4,
    parameter int unsigned N_IN    = 2,
    parameter int unsigned DEB_CYC = 1000,
    parameter int unsigned DIV_W   = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    input  logic [N_IN-1:0]   pio_in,
    output logic [N_OUT-1:0]  pio_out,
    output logic              irq
);

    localparam int unsigned CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEB_CYC - 1);

    localparam logic [2:0] A_DATA_IN   = 3'd0;
    localparam logic [2:0] A_DATA_OUT  = 3'd1;
    localparam logic [2:0] A_BLINK_EN  = 3'd2;
    localparam logic [2:0] A_BLINK_DIV = 3'd3;
    localparam logic [2:0] A_EDGE_CAP  = 3'd4;
    localparam logic [2:0] A_IRQ_MASK  = 3'd5;
    localparam logic [2:0] A_EDGE_SEL  = 3'd6;

    logic [N_IN-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_IN-1:0]  deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [CNT_W-1:0] deb_cnt_q [N_IN];
    logic [CNT_W-1:0] deb_cnt_d [N_IN];
    logic [N_OUT-1:0] data_out_q, data_out_d, blink_en_q, blink_en_d;
    logic [N_OUT-1:0] pio_out_q, pio_out_d;
    logic [DIV_W-1:0] div_q, div_d, bcnt_q, bcnt_d;
    logic             phase_q, phase_d;
    logic [N_IN-1:0]  edge_cap_q, edge_cap_d, irq_mask_q, irq_mask_d;
    logic [N_IN-1:0]  edge_sel_q, edge_sel_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic [N_IN-1:0]  edge_hit_c;
    logic [31:0]      rmux_c;
    logic             wdata_unused_c;

    // Upper writedata bits are intentionally discarded for narrow registers.
    assign wdata_unused_c = ^avs_writedata;

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign pio_out           = pio_out_q;
    assign irq               = irq_q;

    // Read mux sees only registered state, so a same-cycle write returns the old value.
    always_comb begin
        rmux_c = '0;
        case (avs_address)
            A_DATA_IN:   rmux_c = 32'(deb_q);
            A_DATA_OUT:  rmux_c = 32'(data_out_q);
            A_BLINK_EN:  rmux_c = 32'(blink_en_q);
            A_BLINK_DIV: rmux_c = 32'(div_q);
            A_EDGE_CAP:  rmux_c = 32'(edge_cap_q);
            A_IRQ_MASK:  rmux_c = 32'(irq_mask_q);
            A_EDGE_SEL:  rmux_c = 32'(edge_sel_q);
            default:     rmux_c = '0;
        endcase
    end

    assign edge_hit_c = (deb_q & ~deb_prev_q & ~edge_sel_q)
                      | (~deb_q & deb_prev_q & edge_sel_q);

    always_comb begin
        sync1_d    = pio_in;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        deb_cnt_d  = deb_cnt_q;
        data_out_d = data_out_q;
        blink_en_d = blink_en_q;
        div_d      = div_q;
        bcnt_d     = bcnt_q;
        phase_d    = phase_q;
        edge_cap_d = edge_cap_q;
        irq_mask_d = irq_mask_q;
        edge_sel_d = edge_sel_q;
        irq_d      = |(edge_cap_q & irq_mask_q);
        pio_out_d  = data_out_q & (~blink_en_q | {N_OUT{phase_q}});
        rvalid_d   = avs_read;
        rdata_d    = avs_read ? rmux_c : '0;

        // Counter only runs while the synced value disagrees with the accepted one.
        for (int i = 0; i < int'(N_IN); i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] >= CNT_TC) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
            end
        end

        if (avs_write) begin
            case (avs_address)
                A_DATA_OUT: data_out_d = avs_writedata[N_OUT-1:0];
                A_BLINK_EN: blink_en_d = avs_writedata[N_OUT-1:0];
                A_EDGE_CAP: edge_cap_d = edge_cap_q & ~avs_writedata[N_IN-1:0];
                A_IRQ_MASK: irq_mask_d = avs_writedata[N_IN-1:0];
                A_EDGE_SEL: edge_sel_d = avs_writedata[N_IN-1:0];
                default: ;
            endcase
        end
        edge_cap_d = edge_cap_d | edge_hit_c;

        if (avs_write && (avs_address == A_BLINK_DIV)) begin
            div_d   = avs_writedata[DIV_W-1:0];
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (div_q == '0) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (bcnt_q >= (div_q - DIV_W'(1))) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < int'(N_IN); i++) deb_cnt_q[i] <= '0;
            data_out_q <= '0;
            blink_en_q <= '0;
            div_q      <= '0;
            bcnt_q     <= '0;
            phase_q    <= 1'b1;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            edge_sel_q <= '0;
            pio_out_q  <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            deb_cnt_q  <= deb_cnt_d;
            data_out_q <= data_out_d;
            blink_en_q <= blink_en_d;
            div_q      <= div_d;
            bcnt_q     <= bcnt_d;
            phase_q    <= phase_d;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            edge_sel_q <= edge_sel_d;
            pio_out_q  <= pio_out_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_pio_gpio_ctrl.sv
// Directed bench for pio_gpio_ctrl with a short debounce window.
module tb_pio_gpio_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [1:0]  pio_in;
    logic [3:0]  pio_out;
    logic        irq;

    int errors = 0;
    int checks = 0;

    pio_gpio_ctrl #(
        .N_OUT(4), .N_IN(2), .DEB_CYC(8), .DIV_W(24)
    ) dut (
        .clk(clk),
        .reset(reset),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid),
        .pio_in(pio_in),
        .pio_out(pio_out),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write     = 1'b0;
    endtask

    // Issues one read and checks the returned word one cycle later.
    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read    = 1'b0;
        chk({tag, "_valid"}, 32'(avs_readdatavalid), 32'd1);
        chk(tag, avs_readdata, exp);
    endtask

    initial begin
        reset = 1'b1; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; pio_in = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state and full register map
        chk("rst_pio_out", 32'(pio_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rvalid", 32'(avs_readdatavalid), 32'h0);
        for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_rd%0d", a), 3'(a), 32'h0);
        tick();
        chk("rvalid_single_pulse", 32'(avs_readdatavalid), 32'h0);

        // Output register and width truncation
        wr(3'd1, 32'h0000_000A);
        tick();
        chk("pio_out_A", 32'(pio_out), 32'hA);
        rd_chk("rd_data_out_A", 3'd1, 32'h0000_000A);
        wr(3'd1, 32'hFFFF_FFF5);
        rd_chk("rd_data_out_trunc", 3'd1, 32'h5);
        chk("pio_out_5", 32'(pio_out), 32'h5);

        // Simultaneous read and write returns the pre-write value
        avs_address = 3'd1; avs_writedata = 32'hA; avs_write = 1'b1; avs_read = 1'b1;
        tick();
        avs_write = 1'b0; avs_read = 1'b0;
        chk("rw_same_cycle_old", avs_readdata, 32'h5);
        rd_chk("rw_same_cycle_new", 3'd1, 32'hA);

        // Debounce: 5-cycle glitch is rejected
        wr(3'd5, 32'h1);
        pio_in = 2'b01;
        repeat (5) tick();
        pio_in = 2'b00;
        repeat (20) tick();
        rd_chk("glitch_rejected", 3'd0, 32'h0);
        rd_chk("glitch_no_edge", 3'd4, 32'h0);

        // Debounce: held input accepted exactly 10 cycles after the raw edge
        pio_in = 2'b01;
        repeat (9) tick();
        rd_chk("deb_before_tc", 3'd0, 32'h0);
        rd_chk("deb_at_tc", 3'd0, 32'h1);
        rd_chk("edge_cap_rise", 3'd4, 32'h1);
        chk("irq_set", 32'(irq), 32'h1);

        // W1C clears the capture; irq follows one cycle later
        wr(3'd4, 32'h1);
        chk("irq_lag", 32'(irq), 32'h1);
        tick();
        chk("irq_cleared", 32'(irq), 32'h0);
        rd_chk("edge_cap_cleared", 3'd4, 32'h0);

        // Falling-edge select; W1C landing in the same cycle as the capture
        wr(3'd6, 32'h1);
        pio_in = 2'b00;
        repeat (10) tick();
        wr(3'd4, 32'h1);
        rd_chk("set_beats_w1c", 3'd4, 32'h1);
        chk("irq_fall", 32'(irq), 32'h1);
        rd_chk("data_in_fell", 3'd0, 32'h0);

        // Blink: bits [1:0] toggle every 4 cycles, [3:2] steady
        wr(3'd1, 32'hF);
        wr(3'd2, 32'h3);
        wr(3'd3, 32'd4);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("blink_k%0d", k), 32'(pio_out), (((k - 1) / 4) % 2 == 0) ? 32'hF : 32'hC);
        end
        rd_chk("rd_blink_div", 3'd3, 32'd4);
        wr(3'd3, 32'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("blink_off_%0d", k), 32'(pio_out), 32'hF);
            tick();
        end

        // Reset mid-blink with an edge pending and a read in flight
        wr(3'd3, 32'd4);
        repeat (5) tick();
        chk("pre_reset_blink_low", 32'(pio_out), 32'hC);
        chk("pre_reset_irq", 32'(irq), 32'h1);
        reset = 1'b1; avs_read = 1'b1; avs_address = 3'd1;
        tick();
        reset = 1'b0; avs_read = 1'b0;
        chk("mid_rst_pio_out", 32'(pio_out), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        chk("mid_rst_rvalid", 32'(avs_readdatavalid), 32'h0);
        chk("mid_rst_rdata", avs_readdata, 32'h0);
        for (int a = 0; a < 8; a++) rd_chk($sformatf("mid_rst_rd%0d", a), 3'(a), 32'h0);

        // Phase is back at 1: blink-enabled output lights immediately
        wr(3'd1, 32'h3);
        wr(3'd2, 32'h3);
        tick();
        chk("post_rst_phase_one", 32'(pio_out), 32'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
